sram_ctrl: RTL

Single-port controller that turns a simple request/acknowledge handshake from the CPU/PPU-side logic into the strobe sequence of the board's asynchronous 8-bit SRAM (16-bit address; active-low CE/OE/WE/UB/LB; shared bidirectional data bus). It sits between the internal bus arbiter and the SRAM pins. It owns all SRAM timing, bus turnaround and tristate control. Exactly one access is in flight at a time.

---
 rtl/sram_ctrl_if.sv | 14 +
 rtl/sram_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/sram_ctrl_if.sv
// rtl/sram_ctrl_if.sv - request/acknowledge bus between arbiter and sram_ctrl
interface sram_ctrl_if;
   logic        req;
   logic        wr;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        ready;
   logic [7:0]  rdata;
   logic        rvalid;
   logic        wdone;

   modport master (output req, wr, addr, wdata, input ready, rdata, rvalid, wdone);
   modport slave  (input req, wr, addr, wdata, output ready, rdata, rvalid, wdone);
endinterface

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - strobe sequencer for an asynchronous 8-bit SRAM
module sram_ctrl #(
   parameter int RD_CYCLES = 2,
   parameter int WR_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Reset_n,
   sram_ctrl_if.slave  bus,
   output logic [15:0] SRAM_ADDR,
   inout  wire  [7:0]  SRAM_DQ,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR_SETUP,
      S_WR_PULSE,
      S_WR_HOLD
   } state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt;
   logic        accept;
   logic        rd_last;

   // Next-cycle strobe values decoded from the next state, then registered
   logic        ce_d, oe_d, we_d, drv_d, rdy_d;

   logic        ce_q, oe_q, we_q, dq_oe, ready_q;
   logic        rvalid_q, wdone_q;
   logic [15:0] addr_q;
   logic [7:0]  wdata_q;
   logic [7:0]  rdata_q;

   assign accept  = (state == S_IDLE) && bus.req;
   assign rd_last = (state == S_RD) && (cnt == 4'd0);

   // State register plus the shared pulse-width down-counter
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         if (accept)
            cnt <= bus.wr ? 4'(WR_CYCLES - 1) : 4'(RD_CYCLES - 1);
         else if ((state == S_RD || state == S_WR_PULSE) && cnt != 4'd0)
            cnt <= cnt - 1'b1;
      end
   end

   // Next-state logic: one access in flight, write has fixed setup and hold cycles
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:     if (bus.req) state_nx = bus.wr ? S_WR_SETUP : S_RD;
         S_RD:       if (cnt == 4'd0) state_nx = S_IDLE;
         S_WR_SETUP: state_nx = S_WR_PULSE;
         S_WR_PULSE: if (cnt == 4'd0) state_nx = S_WR_HOLD;
         S_WR_HOLD:  state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
   end

   // Output decode from the next state so every pin comes straight from a flop
   always_comb begin
      ce_d  = 1'b1;
      oe_d  = 1'b1;
      we_d  = 1'b1;
      drv_d = 1'b0;
      rdy_d = 1'b0;
      unique case (state_nx)
         S_IDLE:     rdy_d = 1'b1;
         S_RD:       begin ce_d = 1'b0; oe_d = 1'b0; end
         S_WR_SETUP: begin ce_d = 1'b0; drv_d = 1'b1; end
         S_WR_PULSE: begin ce_d = 1'b0; we_d = 1'b0; drv_d = 1'b1; end
         S_WR_HOLD:  begin ce_d = 1'b0; drv_d = 1'b1; end
         default:    rdy_d = 1'b1;
      endcase
   end

   // Pin registers, request latches, read capture and completion pulses
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         ce_q     <= 1'b1;
         oe_q     <= 1'b1;
         we_q     <= 1'b1;
         dq_oe    <= 1'b0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         wdone_q  <= 1'b0;
         addr_q   <= 16'h0000;
         wdata_q  <= 8'h00;
         rdata_q  <= 8'h00;
      end else begin
         ce_q     <= ce_d;
         oe_q     <= oe_d;
         we_q     <= we_d;
         dq_oe    <= drv_d;
         ready_q  <= rdy_d;
         rvalid_q <= rd_last;
         wdone_q  <= (state == S_WR_HOLD);
         if (accept) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
         end
         if (rd_last)
            rdata_q <= SRAM_DQ;
      end
   end

   assign SRAM_ADDR  = addr_q;
   assign SRAM_DQ    = dq_oe ? wdata_q : 8'hzz;
   assign SRAM_CE_N  = ce_q;
   assign SRAM_LB_N  = ce_q;
   assign SRAM_UB_N  = 1'b1;
   assign SRAM_OE_N  = oe_q;
   assign SRAM_WE_N  = we_q;

   assign bus.ready  = ready_q;
   assign bus.rdata  = rdata_q;
   assign bus.rvalid = rvalid_q;
   assign bus.wdone  = wdone_q;

endmodule
